// File: rtl/inert_intf_if.sv
// IMU-side bus of the inertial interface: SPI lines plus the IMU data-ready interrupt.
//   SS_n  : SPI slave select, active-low (initiator -> IMU)
//   SCLK  : SPI clock, idles high      (initiator -> IMU)
//   MOSI  : SPI data to IMU            (initiator -> IMU)
//   MISO  : SPI data from IMU          (IMU -> initiator)
//   INT   : IMU data-ready, async      (IMU -> initiator)
interface inert_intf_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic INT;

  modport master (output SS_n, output SCLK, output MOSI, input MISO, input INT);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO, output INT);
endinterface

// File: rtl/inert_intf.sv
// Producer side of the balance loop: SPI initiator to the 6-axis IMU.
// Configures the IMU after reset, then on every data-ready interrupt reads the
// pitch rate and Z-accel, removes offsets, integrates pitch with accel fusion
// and publishes ptch/ptch_rt with a one-cycle vld pulse.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   spi         : IMU bus (master modport: SS_n, SCLK, MOSI out; MISO, INT in)
//   ptch        : signed pitch estimate
//   ptch_rt     : signed offset-compensated pitch rate
//   vld         : one-clk pulse when ptch/ptch_rt update
//   init_done   : high once IMU configuration is complete
module inert_intf #(
  parameter int unsigned SCLK_DIV       = 16,
  parameter int unsigned INIT_W         = 16,
  parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
  parameter logic [15:0] AZ_OFFSET      = 16'h00A0,
  parameter bit          FUSION_EN      = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  inert_intf_if.master       spi,
  output logic [15:0]        ptch,
  output logic [15:0]        ptch_rt,
  output logic               vld,
  output logic               init_done
);

  localparam int unsigned HALF    = SCLK_DIV / 2;
  localparam int unsigned HCNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned STEP_W  = 6;
  localparam int unsigned INTEG_W = 27;

  // Frame timeline in half SCLK periods: 1..32 alternate fall/rise,
  // 33 raises SS_n, 34..35 hold the inter-frame gap.
  localparam logic [STEP_W-1:0] STEP_LAST_BIT = STEP_W'(32);
  localparam logic [STEP_W-1:0] STEP_SS_UP    = STEP_W'(33);
  localparam logic [STEP_W-1:0] STEP_LAST     = STEP_W'(35);

  typedef enum logic [2:0] {
    S_INIT_WAIT,
    S_INIT_WR,
    S_IDLE,
    S_RD,
    S_INTEG
  } state_t;

  state_t                    state_q;
  logic [INIT_W-1:0]         init_cnt_q;
  logic [1:0]                idx_q;
  logic                      spi_act_q;
  logic [HCNT_W-1:0]         hcnt_q;
  logic [STEP_W-1:0]         step_q;
  logic [15:0]               tx_q;
  logic [7:0]                rx_q;
  logic                      ss_n_q;
  logic                      sclk_q;
  logic                      mosi_q;
  logic                      int_meta_q;
  logic                      int_sync_q;
  logic                      int_prev_q;
  logic                      pend_q;
  logic                      init_done_q;
  logic [3:0][7:0]           rd_q;
  logic signed [INTEG_W-1:0] integ_q;
  logic [15:0]               ptch_q;
  logic [15:0]               ptch_rt_q;
  logic                      vld_q;

  function automatic logic [15:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 16'h0D02;
      2'd1:    return 16'h1053;
      2'd2:    return 16'h1150;
      default: return 16'h1460;
    endcase
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [1:0] i);
    case (i)
      2'd0:    return 16'hA200;
      2'd1:    return 16'hA300;
      2'd2:    return 16'hAC00;
      default: return 16'hAD00;
    endcase
  endfunction

  logic half_tick;
  logic frame_done;
  logic int_rise;

  assign half_tick  = (hcnt_q == HCNT_W'(HALF - 1));
  assign frame_done = spi_act_q && half_tick && (step_q == STEP_LAST);
  assign int_rise   = int_sync_q & ~int_prev_q;

  // Offset compensation, accel-derived pitch and the next integrator value
  logic [15:0]               rt;
  logic [15:0]               az;
  logic signed [INTEG_W-1:0] rt_x;
  logic signed [INTEG_W-1:0] az_x;
  logic signed [INTEG_W-1:0] prod;
  logic signed [INTEG_W-1:0] ptch_acc;
  logic signed [INTEG_W-1:0] ptch_x;
  logic signed [INTEG_W-1:0] fus;
  logic signed [INTEG_W-1:0] integ_nxt;

  assign rt        = {rd_q[1], rd_q[0]} - PTCH_RT_OFFSET;
  assign az        = {rd_q[3], rd_q[2]} - AZ_OFFSET;
  assign rt_x      = {{(INTEG_W-16){rt[15]}}, rt};
  assign az_x      = {{(INTEG_W-16){az[15]}}, az};
  assign prod      = az_x * 27'sd327;
  assign ptch_acc  = prod >>> 13;
  assign ptch_x    = {{(INTEG_W-16){ptch_q[15]}}, ptch_q};
  assign fus       = FUSION_EN ? ((ptch_acc > ptch_x) ? 27'sd1024 : -27'sd1024) : '0;
  assign integ_nxt = integ_q - rt_x + fus;

  // Frame launch decode: which state starts a new SPI frame and with which command
  logic        launch;
  logic [15:0] launch_cmd;

  always_comb begin
    launch     = 1'b0;
    launch_cmd = '0;
    case (state_q)
      S_INIT_WAIT: if (&init_cnt_q) begin
        launch     = 1'b1;
        launch_cmd = init_cmd(2'd0);
      end
      S_INIT_WR: if (frame_done && (idx_q != 2'd3)) begin
        launch     = 1'b1;
        launch_cmd = init_cmd(idx_q + 2'd1);
      end
      S_IDLE: if (pend_q) begin
        launch     = 1'b1;
        launch_cmd = rd_cmd(2'd0);
      end
      S_RD: if (frame_done && (idx_q != 2'd3)) begin
        launch     = 1'b1;
        launch_cmd = rd_cmd(idx_q + 2'd1);
      end
      default: ;
    endcase
  end

  // Sequencer, SPI shift engine, INT synchroniser and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT_WAIT;
      init_cnt_q  <= '0;
      idx_q       <= '0;
      spi_act_q   <= 1'b0;
      hcnt_q      <= '0;
      step_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      ss_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      int_meta_q  <= 1'b0;
      int_sync_q  <= 1'b0;
      int_prev_q  <= 1'b0;
      pend_q      <= 1'b0;
      init_done_q <= 1'b0;
      rd_q        <= '0;
      integ_q     <= '0;
      ptch_q      <= '0;
      ptch_rt_q   <= '0;
      vld_q       <= 1'b0;
    end else begin
      vld_q      <= 1'b0;
      int_meta_q <= spi.INT;
      int_sync_q <= int_meta_q;
      int_prev_q <= int_sync_q;

      // SPI engine: MOSI changes on SCLK fall, MISO sampled on SCLK rise
      if (launch) begin
        spi_act_q <= 1'b1;
        ss_n_q    <= 1'b0;
        hcnt_q    <= '0;
        step_q    <= STEP_W'(1);
        tx_q      <= launch_cmd;
      end else if (spi_act_q) begin
        if (half_tick) begin
          hcnt_q <= '0;
          step_q <= step_q + STEP_W'(1);
          if (step_q <= STEP_LAST_BIT) begin
            if (step_q[0]) begin
              sclk_q <= 1'b0;
              mosi_q <= tx_q[15];
              tx_q   <= {tx_q[14:0], 1'b0};
            end else begin
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[6:0], spi.MISO};
            end
          end else if (step_q == STEP_SS_UP) begin
            ss_n_q <= 1'b1;
          end else if (step_q == STEP_LAST) begin
            spi_act_q <= 1'b0;
          end
        end else begin
          hcnt_q <= hcnt_q + HCNT_W'(1);
        end
      end

      case (state_q)
        S_INIT_WAIT: begin
          init_cnt_q <= init_cnt_q + INIT_W'(1);
          if (&init_cnt_q) begin
            idx_q   <= '0;
            state_q <= S_INIT_WR;
          end
        end
        S_INIT_WR: if (frame_done) begin
          if (idx_q == 2'd3) begin
            init_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        S_IDLE: if (pend_q) begin
          pend_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= S_RD;
        end
        S_RD: if (frame_done) begin
          rd_q[idx_q] <= rx_q;
          if (idx_q == 2'd3) begin
            state_q <= S_INTEG;
          end else begin
            idx_q <= idx_q + 2'd1;
          end
        end
        S_INTEG: begin
          integ_q   <= integ_nxt;
          ptch_q    <= integ_nxt[INTEG_W-1:INTEG_W-16];
          ptch_rt_q <= rt;
          vld_q     <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_INIT_WAIT;
      endcase

      // A new edge wins over the clear in IDLE so back-to-back edges are never lost
      if (int_rise && init_done_q) pend_q <= 1'b1;
    end
  end

  assign spi.SS_n  = ss_n_q;
  assign spi.SCLK  = sclk_q;
  assign spi.MOSI  = mosi_q;
  assign ptch      = ptch_q;
  assign ptch_rt   = ptch_rt_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: dut0 with fusion disabled, dut1 with fusion enabled,
// each attached to a behavioural IMU that logs frames and answers reads.
module tb_inert_intf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inert_intf_if bus0 ();
  inert_intf_if bus1 ();

  logic [15:0] ptch0, ptch1, ptch_rt0, ptch_rt1;
  logic        vld0, vld1, initd0, initd1;

  inert_intf #(.SCLK_DIV(16), .INIT_W(4), .PTCH_RT_OFFSET(16'h0050),
               .AZ_OFFSET(16'h00A0), .FUSION_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .spi(bus0), .ptch(ptch0), .ptch_rt(ptch_rt0),
    .vld(vld0), .init_done(initd0));

  inert_intf #(.SCLK_DIV(16), .INIT_W(4), .PTCH_RT_OFFSET(16'h0050),
               .AZ_OFFSET(16'h00A0), .FUSION_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi(bus1), .ptch(ptch1), .ptch_rt(ptch_rt1),
    .vld(vld1), .init_done(initd1));

  logic [1:0] ss_w, sclk_w, mosi_w, vld_w, initd_w;
  logic [1:0] miso_r = 2'b00;
  logic [1:0] int_r  = 2'b00;

  assign ss_w    = {bus1.SS_n, bus0.SS_n};
  assign sclk_w  = {bus1.SCLK, bus0.SCLK};
  assign mosi_w  = {bus1.MOSI, bus0.MOSI};
  assign vld_w   = {vld1, vld0};
  assign initd_w = {initd1, initd0};
  assign bus0.MISO = miso_r[0];
  assign bus1.MISO = miso_r[1];
  assign bus0.INT  = int_r[0];
  assign bus1.INT  = int_r[1];

  // IMU model state
  logic [1:0]  ss_p = 2'b11, sclk_p = 2'b11, mosi_p = 2'b00;
  int          bcnt [2];
  logic [15:0] rxw [2];
  logic [7:0]  txb [2];
  logic [15:0] flog [2][128];
  int          fcnt [2];
  int          short_cnt [2];
  int          viol [2];
  int          vcnt [2];
  logic [15:0] imu_rate [2];
  logic [15:0] imu_az [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] imu_rd(input int i, input logic [7:0] a);
    logic [15:0] r, z;
    r = imu_rate[i];
    z = imu_az[i];
    case (a)
      8'hA2:   return r[7:0];
      8'hA3:   return r[15:8];
      8'hAC:   return z[7:0];
      8'hAD:   return z[15:8];
      default: return 8'h00;
    endcase
  endfunction

  // IMU slave: shifts MOSI on SCLK rise, drives the read byte on SCLK fall,
  // logs complete frames and flags SCLK/MOSI activity while deselected.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ss_p[i] && !ss_w[i]) begin
        bcnt[i] = 0;
        rxw[i] = '0;
        miso_r[i] = 1'b0;
      end
      if (!ss_w[i] && sclk_p[i] && !sclk_w[i]) begin
        logic [7:0] t;
        t = txb[i];
        miso_r[i] = (bcnt[i] >= 8 && bcnt[i] < 16) ? t[15 - bcnt[i]] : 1'b0;
      end
      if (!ss_w[i] && !sclk_p[i] && sclk_w[i]) begin
        rxw[i] = {rxw[i][14:0], mosi_w[i]};
        bcnt[i]++;
        if (bcnt[i] == 8) txb[i] = imu_rd(i, rxw[i][7:0]);
      end
      if (!ss_p[i] && ss_w[i]) begin
        if (bcnt[i] == 16 && fcnt[i] < 128) begin
          flog[i][fcnt[i]] = rxw[i];
          fcnt[i]++;
        end else begin
          short_cnt[i]++;
        end
      end
      if (ss_p[i] && ss_w[i] && (!sclk_w[i] || (mosi_w[i] !== mosi_p[i]))) viol[i]++;
      if (vld_w[i]) vcnt[i]++;
      ss_p[i]   = ss_w[i];
      sclk_p[i] = sclk_w[i];
      mosi_p[i] = mosi_w[i];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] init_exp [4];
  logic [15:0] rd_exp [4];

  task automatic pulse_int(input int i);
    @(negedge clk);
    int_r[i] = 1'b1;
    repeat (4) @(negedge clk);
    int_r[i] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_vld(input int i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      @(negedge clk);
      if (vld_w[i]) ok = 1'b1;
    end
  endtask

  task automatic wait_init(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      @(negedge clk);
      if (initd_w == 2'b11) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    bit ok;
    int f0 [2];
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ss_w !== 2'b11) begin errors++; $display("FAIL reset_ss_n: got %b exp 11", ss_w); end
    checks++; if (sclk_w !== 2'b11) begin errors++; $display("FAIL reset_sclk: got %b exp 11", sclk_w); end
    checks++; if (mosi_w !== 2'b00) begin errors++; $display("FAIL reset_mosi: got %b exp 00", mosi_w); end
    checks++; if ({vld_w, initd_w} !== 4'b0000) begin errors++; $display("FAIL reset_vld_init: got %b exp 0000", {vld_w, initd_w}); end
    checks++; if ({ptch0, ptch_rt0, ptch1, ptch_rt1} !== 64'h0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", {ptch0, ptch_rt0, ptch1, ptch_rt1}); end
    f0[0] = fcnt[0];
    f0[1] = fcnt[1];
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++; if (ss_w !== 2'b11) begin errors++; $display("FAIL init_wait_ss_high: got %b exp 11", ss_w); end
    @(negedge clk);
    checks++; if (ss_w !== 2'b00) begin errors++; $display("FAIL init_first_ss_fall: got %b exp 00", ss_w); end
    checks++; if (initd_w !== 2'b00) begin errors++; $display("FAIL init_done_early: got %b exp 00", initd_w); end
    wait_init(ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_done_timeout: got %b exp 11", initd_w); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (fcnt[i] - f0[i] !== 4) begin errors++; $display("FAIL init_frame_count dut%0d: got %0d exp 4", i, fcnt[i] - f0[i]); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (flog[i][f0[i] + k] !== init_exp[k]) begin errors++; $display("FAIL init_cmd dut%0d #%0d: got %h exp %h", i, k, flog[i][f0[i] + k], init_exp[k]); end
      end
    end
  endtask

  task automatic test_fusion_off;
    bit ok;
    int f0, v0;
    imu_rate[0] = 16'h0150;
    imu_az[0]   = 16'h00A0;
    f0 = fcnt[0];
    v0 = vcnt[0];
    checks++; if (ptch0 !== 16'h0000) begin errors++; $display("FAIL off_ptch_start: got %h exp 0000", ptch0); end
    for (int p = 0; p < 8; p++) begin
      pulse_int(0);
      wait_vld(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL off_vld_timeout #%0d: got 0 exp 1", p); end
      checks++; if (ptch_rt0 !== 16'h0100) begin errors++; $display("FAIL off_ptch_rt #%0d: got %h exp 0100", p, ptch_rt0); end
      checks++; if (ptch0 !== 16'hFFFF) begin errors++; $display("FAIL off_ptch #%0d: got %h exp FFFF", p, ptch0); end
    end
    repeat (50) @(negedge clk);
    checks++; if (vcnt[0] - v0 !== 8) begin errors++; $display("FAIL off_vld_count: got %0d exp 8", vcnt[0] - v0); end
    checks++; if (fcnt[0] - f0 !== 32) begin errors++; $display("FAIL off_frame_count: got %0d exp 32", fcnt[0] - f0); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (flog[0][f0 + k] !== rd_exp[k]) begin errors++; $display("FAIL rd_cmd #%0d: got %h exp %h", k, flog[0][f0 + k], rd_exp[k]); end
    end
  endtask

  task automatic test_fusion_on;
    bit ok;
    logic [15:0] rate_t [6], az_t [6], ptch_t [6], rt_t [6];
    rate_t = '{16'h0050, 16'h0050, 16'h0050, 16'h0050, 16'h0050, 16'h0040};
    az_t   = '{16'h00A0, 16'h00A0, 16'h00A0, 16'h00A0, 16'h10A0, 16'h10A0};
    ptch_t = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001};
    rt_t   = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFF0};
    for (int p = 0; p < 6; p++) begin
      imu_rate[1] = rate_t[p];
      imu_az[1]   = az_t[p];
      pulse_int(1);
      wait_vld(1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL on_vld_timeout #%0d: got 0 exp 1", p); end
      checks++; if (ptch_rt1 !== rt_t[p]) begin errors++; $display("FAIL on_ptch_rt #%0d: got %h exp %h", p, ptch_rt1, rt_t[p]); end
      checks++; if (ptch1 !== ptch_t[p]) begin errors++; $display("FAIL on_ptch #%0d: got %h exp %h", p, ptch1, ptch_t[p]); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int f0, v0;
    f0 = fcnt[0];
    v0 = vcnt[0];
    pulse_int(0);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (fcnt[0] >= f0 + 1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first_frame_timeout: got %0d exp %0d", fcnt[0], f0 + 1); end
    pulse_int(0);
    for (int p = 0; p < 2; p++) begin
      wait_vld(0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_vld_timeout #%0d: got 0 exp 1", p); end
      checks++; if (ptch0 !== 16'hFFFE) begin errors++; $display("FAIL b2b_ptch #%0d: got %h exp FFFE", p, ptch0); end
    end
    repeat (1500) @(negedge clk);
    checks++; if (vcnt[0] - v0 !== 2) begin errors++; $display("FAIL b2b_vld_count: got %0d exp 2", vcnt[0] - v0); end
    checks++; if (fcnt[0] - f0 !== 8) begin errors++; $display("FAIL b2b_frame_count: got %0d exp 8", fcnt[0] - f0); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (flog[0][f0 + 4 + k] !== rd_exp[k]) begin errors++; $display("FAIL b2b_rd_cmd #%0d: got %h exp %h", k, flog[0][f0 + 4 + k], rd_exp[k]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    bit ok;
    int f0, v0, s0;
    pulse_int(0);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (!ss_w[0] && bcnt[0] == 7) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL midrst_bit7_timeout: got %0d exp 7", bcnt[0]); end
    f0 = fcnt[0];
    v0 = vcnt[0];
    s0 = short_cnt[0];
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ss_w[0], sclk_w[0], mosi_w[0]} !== 3'b110) begin errors++; $display("FAIL midrst_async: got %b exp 110", {ss_w[0], sclk_w[0], mosi_w[0]}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_init(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_init_timeout: got %b exp 11", initd_w); end
    repeat (400) @(negedge clk);
    checks++; if (vcnt[0] !== v0) begin errors++; $display("FAIL midrst_vld: got %0d exp %0d", vcnt[0], v0); end
    checks++; if (short_cnt[0] - s0 !== 1) begin errors++; $display("FAIL midrst_aborted_frames: got %0d exp 1", short_cnt[0] - s0); end
    checks++; if (ptch0 !== 16'h0000) begin errors++; $display("FAIL midrst_ptch: got %h exp 0000", ptch0); end
    checks++; if (fcnt[0] - f0 !== 4) begin errors++; $display("FAIL midrst_frame_count: got %0d exp 4", fcnt[0] - f0); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (flog[0][f0 + k] !== init_exp[k]) begin errors++; $display("FAIL midrst_init_cmd #%0d: got %h exp %h", k, flog[0][f0 + k], init_exp[k]); end
    end
  endtask

  task automatic test_int_before_init;
    bit ok;
    int f0 [2];
    int v0 [2];
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      f0[i] = fcnt[i];
      v0[i] = vcnt[i];
    end
    rst_n = 1'b1;
    pulse_int(0);
    pulse_int(1);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (fcnt[0] >= f0[0] + 1) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL early_first_frame_timeout: got %0d exp %0d", fcnt[0], f0[0] + 1); end
    checks++; if (initd_w !== 2'b00) begin errors++; $display("FAIL early_init_done: got %b exp 00", initd_w); end
    pulse_int(0);
    pulse_int(1);
    wait_init(ok);
    checks++; if (!ok) begin errors++; $display("FAIL early_init_timeout: got %b exp 11", initd_w); end
    repeat (1500) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++; if (fcnt[i] - f0[i] !== 4) begin errors++; $display("FAIL early_frame_count dut%0d: got %0d exp 4", i, fcnt[i] - f0[i]); end
      checks++; if (vcnt[i] !== v0[i]) begin errors++; $display("FAIL early_vld dut%0d: got %0d exp %0d", i, vcnt[i], v0[i]); end
      checks++; if (viol[i] !== 0) begin errors++; $display("FAIL idle_bus_activity dut%0d: got %0d exp 0", i, viol[i]); end
    end
  endtask

  initial begin
    init_exp = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    rd_exp   = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
    for (int i = 0; i < 2; i++) begin
      bcnt[i] = 0; rxw[i] = '0; txb[i] = '0; fcnt[i] = 0;
      short_cnt[i] = 0; viol[i] = 0; vcnt[i] = 0;
      imu_rate[i] = 16'h0050; imu_az[i] = 16'h00A0;
    end
    test_reset;
    test_fusion_off;
    test_fusion_on;
    test_back_to_back;
    test_reset_mid_frame;
    test_int_before_init;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
